// File: rtl/axis_sample_source.sv
// axis_sample_source
//
// Plays a host-loaded waveform out of an AXI4-Stream master port at a fixed
// sample rate of one beat every clk_div clocks. Samples are written into an
// internal buffer while idle, then a start pulse streams num_samples of them
// either once or in a continuous loop. Back-pressure never drops or repeats
// a sample. A sample period that cannot issue a new beat because the
// previous one is still waiting is counted in overrun_cnt.
//
// Ports
//   clk, rst_n     : system clock, synchronous active-low reset
//   wr_en/addr/data: buffer write port, accepted only while idle
//   num_samples    : samples per pass (1..depth), latched at start
//   loop           : 1 = repeat the pass forever, latched at start
//   start, stop    : begin playback (idle only) / end playback
//   m_axis_*       : AXI4-Stream master (tdata, tvalid, tlast, tready)
//   busy           : playback (or draining) in progress
//   done           : one-cycle pulse when a one-shot pass completes
//   overrun_cnt    : saturating count of sample ticks lost to back-pressure
module axis_sample_source #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter int depth      = 256,
  parameter int clk_div    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [addr_width:0]   num_samples,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  output logic [data_width-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           overrun_cnt
);

  localparam int                  tick_w   = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [tick_w-1:0]   tick_max = tick_w'(clk_div - 1);
  localparam logic [tick_w-1:0]   tick_one = tick_w'(1);
  localparam logic [addr_width:0] depth_n  = (addr_width + 1)'(depth);
  localparam logic [addr_width:0] one_n    = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] one_a  = addr_width'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [tick_w-1:0]     tick_reg, tick_next;
  logic [addr_width-1:0] idx_reg, idx_next;
  logic [addr_width:0]   num_reg, num_next;
  logic                  loop_reg, loop_next;
  logic                  final_reg, final_next;   // one-shot: last index already read
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  done_reg, done_next;
  logic [15:0]           ovr_reg, ovr_next;

  logic                  rd_en;
  logic [data_width-1:0] rd_data_reg;
  logic [data_width-1:0] mem [depth];

  logic tick, pending, accepted, idx_is_last, start_ok;

  assign tick        = (tick_reg == '0);
  assign pending     = tvalid_reg && !m_axis_tready;
  assign accepted    = tvalid_reg && m_axis_tready;
  assign idx_is_last = ({1'b0, idx_reg} == (num_reg - one_n));
  assign start_ok    = start && !stop && (num_samples != '0) && (num_samples <= depth_n);

  // Buffer: write only while idle, registered read. The read register is the
  // beat data holding register; it only changes when a new beat is issued.
  always_ff @(posedge clk) begin
    if (wr_en && (state_reg == IDLE))
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data_reg <= mem[idx_reg];
  end

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    idx_next    = idx_reg;
    num_next    = num_reg;
    loop_next   = loop_reg;
    final_next  = final_reg;
    tvalid_next = tvalid_reg;
    tlast_next  = tlast_reg;
    done_next   = 1'b0;
    ovr_next    = ovr_reg;
    rd_en       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = RUN;
          num_next   = num_samples;
          loop_next  = loop;
          idx_next   = '0;
          tick_next  = '0;
          final_next = 1'b0;
          ovr_next   = '0;
        end
      end

      RUN: begin
        tick_next = (tick_reg == tick_max) ? '0 : tick_reg + tick_one;
        if (stop) begin
          if (pending) begin
            state_next = DRAIN;
          end else begin
            state_next  = IDLE;
            tvalid_next = 1'b0;
          end
        end else if (accepted && tlast_reg && !loop_reg) begin
          // Final beat of a one-shot pass handed off.
          state_next  = IDLE;
          tvalid_next = 1'b0;
          done_next   = 1'b1;
        end else begin
          if (accepted)
            tvalid_next = 1'b0;
          if (tick && !final_reg) begin
            if (pending) begin
              if (ovr_reg != 16'hFFFF)
                ovr_next = ovr_reg + 16'd1;
            end else begin
              // A beat accepted on this same edge is replaced seamlessly.
              rd_en       = 1'b1;
              tvalid_next = 1'b1;
              tlast_next  = idx_is_last;
              if (idx_is_last) begin
                idx_next   = '0;
                final_next = !loop_reg;
              end else begin
                idx_next = idx_reg + one_a;
              end
            end
          end
        end
      end

      DRAIN: begin
        if (accepted) begin
          state_next  = IDLE;
          tvalid_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      idx_reg    <= '0;
      num_reg    <= '0;
      loop_reg   <= 1'b0;
      final_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      done_reg   <= 1'b0;
      ovr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      idx_reg    <= idx_next;
      num_reg    <= num_next;
      loop_reg   <= loop_next;
      final_reg  <= final_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      done_reg   <= done_next;
      ovr_reg    <= ovr_next;
    end
  end

  // Data and last are forced quiet whenever no beat is offered.
  assign m_axis_tdata  = tvalid_reg ? rd_data_reg : '0;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tvalid_reg && tlast_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign overrun_cnt   = ovr_reg;

endmodule

// File: tb/tb_axis_sample_source.sv
// Testbench for axis_sample_source: directed scenarios, a per-cycle
// behavioural model compared on every falling edge, and hand-computed
// literal expectations for beat timing, values and counters.
module tb_axis_sample_source;

  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int DEPTH   = 256;
  localparam int CLK_DIV = 5;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, loop, start, stop, tready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   num_samples;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, busy, done;
  logic [15:0]   ovr;

  always #5 clk = ~clk;

  axis_sample_source #(
    .data_width(DW), .addr_width(AW), .depth(DEPTH), .clk_div(CLK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_samples(num_samples), .loop(loop), .start(start), .stop(stop),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .busy(busy), .done(done), .overrun_cnt(ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sample ticks fall on fixed multiples of clk_div after the start edge;
  // the buffer is a plain array; beats are issued/held by the stream rules.
  logic [DW-1:0] mem_m [DEPTH];
  bit            m_armed = 1'b0;
  bit            m_busy, m_drain, m_valid, m_last, m_done, m_loop, m_final;
  logic [DW-1:0] m_data;
  int            m_idx, m_num, m_start_edge;
  int unsigned   m_ovr;
  int            m_edge = 0;
  bit            acc_m, pend_m, tick_m;

  always @(posedge clk) begin
    m_edge++;
    if (!rst_n) begin
      m_armed = 1'b1; m_busy = 1'b0; m_drain = 1'b0; m_valid = 1'b0;
      m_last = 1'b0; m_done = 1'b0; m_ovr = 0; m_idx = 0; m_final = 1'b0;
    end else if (m_armed) begin
      m_done = 1'b0;
      acc_m  = m_valid && tready;
      pend_m = m_valid && !tready;
      if (!m_busy) begin
        if (wr_en) mem_m[wr_addr] = wr_data;
        if (start && !stop && int'(num_samples) >= 1 && int'(num_samples) <= DEPTH) begin
          m_busy = 1'b1; m_drain = 1'b0; m_num = int'(num_samples); m_loop = loop;
          m_idx = 0; m_final = 1'b0; m_ovr = 0; m_start_edge = m_edge;
        end
      end else if (m_drain) begin
        if (acc_m) begin m_valid = 1'b0; m_busy = 1'b0; m_drain = 1'b0; end
      end else begin
        tick_m = ((m_edge - m_start_edge - 1) % CLK_DIV) == 0;
        if (stop) begin
          if (pend_m) m_drain = 1'b1;
          else begin m_busy = 1'b0; m_valid = 1'b0; end
        end else if (acc_m && m_last && !m_loop) begin
          m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b1;
        end else begin
          if (acc_m) m_valid = 1'b0;
          if (tick_m && !m_final) begin
            if (pend_m) begin
              if (m_ovr < 32'hFFFF) m_ovr++;
            end else begin
              m_valid = 1'b1;
              m_data  = mem_m[m_idx];
              m_last  = (m_idx == m_num - 1);
              if (m_last) begin m_idx = 0; m_final = !m_loop; end
              else m_idx++;
            end
          end
        end
      end
    end
  end

  // Compare DUT against model every cycle, half a period after the edge.
  always @(negedge clk) begin
    if (m_armed) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("tvalid", tvalid, m_valid);
      check("tlast", tlast, m_valid && m_last);
      check("overrun", ovr, m_ovr);
      if (m_valid) check("tdata", tdata, m_data);
    end
  end

  // Beat / done monitor: a handshake seen here completes on the next edge.
  logic [DW-1:0] beat_data [$];
  bit            beat_last [$];
  int            beat_edge [$];
  int            done_count = 0;
  int            done_edge  = 0;

  always @(negedge clk) begin
    if (tvalid && tready) begin
      beat_data.push_back(tdata);
      beat_last.push_back(tlast);
      beat_edge.push_back(m_edge + 1);
    end
    if (done) begin
      done_count++;
      done_edge = m_edge;
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] vals [4];
  int            s;
  int            n;
  logic [DW-1:0] held;

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic clear_q();
    beat_data.delete(); beat_last.delete(); beat_edge.delete();
    done_count = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step(1);
      if (!busy) break;
    end
    if (k == budget) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_valid(input string name, input logic want, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (tvalid === want) break;
      step(1);
    end
    if (k == budget) check({name, "_valid_timeout"}, 1, 0);
  endtask

  task automatic begin_play(input int num, input logic lp);
    num_samples = (AW + 1)'(num);
    loop  = lp;
    start = 1'b1;
    s     = m_edge + 1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    vals[0] = 16'd0; vals[1] = 16'd1000; vals[2] = -16'sd1000; vals[3] = 16'd32767;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_samples = '0;
    loop = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b1;
    step(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tdata", tdata, 0);
    check("rst_overrun", ovr, 0);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = vals[i];
      step(1);
    end
    wr_en = 1'b0;

    // One-shot, no back-pressure: handshakes at start+2, +7, +12, +17.
    clear_q();
    begin_play(4, 1'b0);
    wait_idle("t1", 100);
    step(2);
    check("t1_beats", beat_data.size(), 4);
    for (int k = 0; k < 4 && k < beat_data.size(); k++) begin
      check($sformatf("t1_data%0d", k), beat_data[k], vals[k]);
      check($sformatf("t1_last%0d", k), beat_last[k], (k == 3));
      check($sformatf("t1_edge%0d", k), beat_edge[k] - s, 2 + 5 * k);
    end
    check("t1_done_cnt", done_count, 1);
    check("t1_done_edge", done_edge - s, 17);
    check("t1_overrun", ovr, 0);

    // Back-pressure for 12 edges after the first beat appears.
    clear_q();
    begin_play(4, 1'b0);
    step(1);
    tready = 1'b0;
    step(12);
    tready = 1'b1;
    wait_idle("t2", 100);
    step(2);
    check("t2_beats", beat_data.size(), 4);
    for (int k = 0; k < 4 && k < beat_data.size(); k++)
      check($sformatf("t2_data%0d", k), beat_data[k], vals[k]);
    check("t2_first_edge", beat_edge.size() > 0 ? beat_edge[0] - s : -1, 14);
    check("t2_overrun", ovr, 2);
    check("t2_done_cnt", done_count, 1);

    // Loop mode, then stop while a beat is held.
    clear_q();
    begin_play(3, 1'b1);
    for (int k = 0; k < 100 && beat_data.size() < 7; k++) step(1);
    check("t3_beats", beat_data.size() >= 7, 1);
    for (int k = 0; k < 7 && k < beat_data.size(); k++) begin
      check($sformatf("t3_data%0d", k), beat_data[k], vals[k % 3]);
      check($sformatf("t3_last%0d", k), beat_last[k], (k % 3 == 2));
    end
    wait_valid("t3a", 1'b0, 20);
    tready = 1'b0;
    wait_valid("t3b", 1'b1, 20);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
    check("t3_drain_busy", busy, 1);
    check("t3_drain_valid", tvalid, 1);
    tready = 1'b1;
    step(1);
    check("t3_stop_busy", busy, 0);
    check("t3_stop_valid", tvalid, 0);
    step(2);
    check("t3_no_done", done_count, 0);
    n = beat_data.size();
    check("t3_final_data", beat_data[n-1], vals[(n-1) % 3]);

    // Illegal starts are ignored.
    begin_play(0, 1'b0);
    check("t4_num0", busy, 0);
    begin_play(DEPTH + 1, 1'b0);
    check("t4_num_over", busy, 0);
    stop = 1'b1;
    begin_play(4, 1'b0);
    stop = 1'b0;
    check("t4_start_stop", busy, 0);

    // Writes during playback are ignored.
    clear_q();
    begin_play(4, 1'b0);
    step(3);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 16'd555;
    step(1);
    wr_en = 1'b0;
    wait_idle("t4", 100);
    step(2);
    check("t4_beats", beat_data.size(), 4);
    if (beat_data.size() > 1) check("t4_data1", beat_data[1], 1000);

    // Reset mid-stream with a held beat and two skipped ticks.
    tready = 1'b0;
    begin_play(4, 1'b1);
    wait_valid("t5", 1'b1, 20);
    step(12);
    check("t5_pre_overrun", ovr, 2);
    rst_n = 1'b0;
    step(1);
    check("t5_rst_valid", tvalid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_overrun", ovr, 0);
    rst_n = 1'b1;
    tready = 1'b1;
    clear_q();
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'd1234;
    num_samples = 4; loop = 1'b0; start = 1'b1; s = m_edge + 1;
    step(1);
    wr_en = 1'b0; start = 1'b0;
    wait_idle("t5", 100);
    step(2);
    check("t5_beats", beat_data.size(), 4);
    if (beat_data.size() > 0) begin
      check("t5_data0", beat_data[0], 1234);
      check("t5_edge0", beat_edge[0] - s, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
